pipelined_adder_tree: RTL and testbench

Pipelined, back-pressurable successor to the combinational adder tree. It reduces LENGTH lanes of DATA_WIDTH data into one sum, registering every tree level. It supports signed/unsigned operands, per-lane masking and multi-beat accumulation delimited by `in_last`. It sits in the AdderUnit between the operand-packing front end and the result consumers (dot-product and MAC datapaths).

---
 rtl/pipelined_adder_tree.sv | 146 ++++++++++++++
 tb/tb_pipelined_adder_tree.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// ============================================================================
// Module   : pipelined_adder_tree
// Purpose  : Reduces LENGTH lanes of DATA_WIDTH data to one sum through a
//            registered binary tree, then accumulates beats into groups that
//            are closed by in_last. Masking, signed/unsigned lanes, and a
//            single global advance for back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipelined_adder_tree #(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 8,
  parameter bit SIGNED     = 1'b1,
  parameter int ACC_BITS   = 4,
  parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(LENGTH) + ACC_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LENGTH*DATA_WIDTH-1:0] in_addends,
  input  logic [LENGTH-1:0]            in_mask,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_sum
);

  localparam int LEVELS = $clog2(LENGTH);

  // Number of operands held at tree level l (level 0 = registered inputs).
  function automatic int lvl_cnt(input int l);
    return (LENGTH + (1 << l) - 1) >> l;
  endfunction

  // Index of the first node of level l in the flattened node array.
  function automatic int lvl_off(input int l);
    int s;
    s = 0;
    for (int k = 0; k < l; k++) s += lvl_cnt(k);
    return s;
  endfunction

  localparam int NODES = lvl_off(LEVELS + 1);
  localparam int ROOT  = lvl_off(LEVELS);

  // All tree levels live in one flat array so that every node is read by
  // exactly one consumer (next level or the accumulator).
  logic [OUT_WIDTH-1:0] node_q [NODES];
  logic [OUT_WIDTH-1:0] node_d [NODES];
  logic [LEVELS:0]      vld_q, vld_d;
  logic [LEVELS:0]      last_q, last_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] group_sum;
  logic                 adv;

  // Whole pipeline moves together unless a finished result is being held.
  always_comb begin
    adv = !out_valid_q || out_ready;
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  // Next-state for the input stage, every tree level and the accumulator.
  always_comb begin
    node_d      = node_q;
    vld_d       = vld_q;
    last_d      = last_q;
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    group_sum   = acc_q + node_q[ROOT];

    if (adv) begin
      // Level 0: mask, then extend each lane to the full result width.
      for (int i = 0; i < LENGTH; i++) begin
        if (!in_mask[i]) begin
          node_d[i] = '0;
        end else if (SIGNED) begin
          node_d[i] = OUT_WIDTH'($signed(in_addends[i*DATA_WIDTH +: DATA_WIDTH]));
        end else begin
          node_d[i] = OUT_WIDTH'(in_addends[i*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
      vld_d[0]  = in_valid;
      last_d[0] = in_last;

      // Pairwise adds; an odd trailing operand is simply forwarded.
      for (int l = 1; l <= LEVELS; l++) begin
        for (int j = 0; j < LENGTH; j++) begin
          if (j < lvl_cnt(l)) begin
            if (2*j + 1 < lvl_cnt(l-1)) begin
              node_d[lvl_off(l) + j] = node_q[lvl_off(l-1) + 2*j]
                                     + node_q[lvl_off(l-1) + 2*j + 1];
            end else begin
              node_d[lvl_off(l) + j] = node_q[lvl_off(l-1) + 2*j];
            end
          end
        end
        vld_d[l]  = vld_q[l-1];
        last_d[l] = last_q[l-1];
      end

      // Accumulator: a closing beat publishes the group and restarts at 0;
      // bubbles leave the partial sum alone.
      out_valid_d = 1'b0;
      if (vld_q[LEVELS]) begin
        if (last_q[LEVELS]) begin
          out_sum_d   = group_sum;
          out_valid_d = 1'b1;
          acc_d       = '0;
        end else begin
          acc_d = group_sum;
        end
      end
    end
  end

  // State registers; reset discards in-flight beats and partial groups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q      <= '{default: '0};
      vld_q       <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      node_q      <= node_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder_tree.sv
// ============================================================================
// Module   : tb_pipelined_adder_tree
// Purpose  : Self-checking bench for pipelined_adder_tree. Four instances
//            (8 lanes signed, 8 lanes unsigned, 5 lanes, 1 lane) share one
//            stimulus; each has its own arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipelined_adder_tree;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_last;
  logic [7:0]    in_mask;
  logic [255:0]  in_addends;
  logic          out_ready;

  wire  [3:0]        rdy;
  wire  [3:0]        ov;
  wire  [3:0][38:0]  sums;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state, one slot per instance
  logic [63:0] acc_m   [4];
  logic [63:0] exp_mem [4][512];
  int          wr_p    [4];
  int          rd_p    [4];

  int          got_lat [4];
  logic [38:0] got_sum [4];
  logic [255:0] vec1;
  logic [255:0] ones;
  logic [63:0]  bexp [4];

  pipelined_adder_tree #(.DATA_WIDTH(32), .LENGTH(8), .SIGNED(1'b1), .ACC_BITS(4)) u_l8s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_addends(in_addends), .in_mask(in_mask), .in_last(in_last),
    .out_valid(ov[0]), .out_ready(out_ready), .out_sum(sums[0]));

  pipelined_adder_tree #(.DATA_WIDTH(32), .LENGTH(8), .SIGNED(1'b0), .ACC_BITS(4)) u_l8u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_addends(in_addends), .in_mask(in_mask), .in_last(in_last),
    .out_valid(ov[1]), .out_ready(out_ready), .out_sum(sums[1]));

  pipelined_adder_tree #(.DATA_WIDTH(32), .LENGTH(5), .SIGNED(1'b1), .ACC_BITS(4)) u_l5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_addends(in_addends[159:0]), .in_mask(in_mask[4:0]), .in_last(in_last),
    .out_valid(ov[2]), .out_ready(out_ready), .out_sum(sums[2]));

  pipelined_adder_tree #(.DATA_WIDTH(32), .LENGTH(1), .SIGNED(1'b1), .ACC_BITS(4)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_addends(in_addends[31:0]), .in_mask(in_mask[0:0]), .in_last(in_last),
    .out_valid(ov[3]), .out_ready(out_ready), .out_sum(sums[3][35:0]));

  assign sums[3][38:36] = 3'b000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int dut_len(input int id);
    case (id)
      0, 1:    return 8;
      2:       return 5;
      default: return 1;
    endcase
  endfunction

  function automatic bit dut_sgn(input int id);
    return id != 1;
  endfunction

  function automatic logic [63:0] ow_mask(input int id);
    return (id == 3) ? ((64'd1 << 36) - 64'd1) : ((64'd1 << 39) - 64'd1);
  endfunction

  // Plain integer sum of the enabled lanes of one beat.
  function automatic logic [63:0] beat_sum(input int id, input logic [255:0] a, input logic [7:0] m);
    logic [63:0] s;
    logic [31:0] v;
    s = '0;
    for (int i = 0; i < dut_len(id); i++) begin
      if (m[i]) begin
        v = a[i*32 +: 32];
        if (dut_sgn(id)) s += {{32{v[31]}}, v};
        else             s += {32'b0, v};
      end
    end
    return s;
  endfunction

  // Scoreboard: handshakes and acceptances observed mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int id = 0; id < 4; id++) begin
        acc_m[id] = '0;
        wr_p[id]  = 0;
        rd_p[id]  = 0;
      end
    end else begin
      for (int id = 0; id < 4; id++) begin
        if (ov[id] && out_ready) begin
          if (rd_p[id] == wr_p[id]) begin
            check_val($sformatf("sb%0d_unexpected_out", id), {63'b0, ov[id]}, 64'd0);
          end else begin
            check_val($sformatf("sb%0d_sum", id), {25'b0, sums[id]}, exp_mem[id][rd_p[id] % 512]);
            rd_p[id]++;
          end
        end
        if (in_valid && rdy[id]) begin
          acc_m[id] = acc_m[id] + beat_sum(id, in_addends, in_mask);
          if (in_last) begin
            exp_mem[id][wr_p[id] % 512] = acc_m[id] & ow_mask(id);
            wr_p[id]++;
            acc_m[id] = '0;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One closing beat into an idle pipeline; records per-instance latency.
  task automatic single_beat(input logic [255:0] a, input logic [7:0] m);
    for (int id = 0; id < 4; id++) begin
      got_lat[id] = -1;
      got_sum[id] = '0;
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_last = 1'b1; in_addends = a; in_mask = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      for (int id = 0; id < 4; id++) begin
        if (ov[id] && got_lat[id] < 0) begin
          got_lat[id] = k;
          got_sum[id] = sums[id];
        end
      end
    end
  endtask

  initial begin
    int v1 [8];
    logic [7:0] bp_mask [4];
    v1 = '{999, 666, -231, 4396, 1189, -1468, -387, 123};
    for (int i = 0; i < 8; i++) vec1[i*32 +: 32] = v1[i];
    ones = '1;
    bp_mask = '{8'hFF, 8'h0F, 8'hF0, 8'h01};

    in_valid = 1'b0; in_last = 1'b0; in_mask = '0; in_addends = '0;
    out_ready = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    check_val("rst_out_valid", {63'b0, ov[0]}, 64'd0);
    check_val("rst_out_sum", {25'b0, sums[0]}, 64'd0);
    check_val("rst_in_ready", {63'b0, rdy[0]}, 64'd1);
    check_val("rst_out_valid_l1", {63'b0, ov[3]}, 64'd0);

    // single beat, all instances, latency per lane count
    single_beat(vec1, 8'hFF);
    check_val("t1_sum", {25'b0, got_sum[0]}, 64'h14A7);
    check_val("t1_lat", 64'(got_lat[0]), 64'd4);
    check_val("t1_lat_unsigned", 64'(got_lat[1]), 64'd4);
    check_val("t6_lat_len5", 64'(got_lat[2]), 64'd4);
    check_val("t6_sum_len5", {25'b0, got_sum[2]}, 64'd7019);
    check_val("t6_lat_len1", 64'(got_lat[3]), 64'd1);
    check_val("t6_sum_len1", {25'b0, got_sum[3]}, 64'd999);

    // masking and extension
    single_beat(vec1, 8'h0F);
    check_val("t2_mask0f", {25'b0, got_sum[0]}, 64'h16C6);
    single_beat(ones, 8'hFF);
    check_val("t2_ones_signed", {25'b0, got_sum[0]}, 64'h7FFFFFFFF8);
    check_val("t2_ones_unsigned", {25'b0, got_sum[1]}, 64'h07FFFFFFF8);

    // three-beat accumulation group
    @(posedge clk); #1;
    in_valid = 1'b1; in_last = 1'b0; in_addends = vec1; in_mask = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) in_last = 1'b1;
      if (k == 2) in_valid = 1'b0;
      check_val($sformatf("t3_valid_k%0d", k), {63'b0, ov[0]}, (k == 6) ? 64'd1 : 64'd0);
      if (k == 6) check_val("t3_acc_sum", {25'b0, sums[0]}, 64'h3DF5);
    end
    single_beat(vec1, 8'hFF);
    check_val("t3_acc_cleared", {25'b0, got_sum[0]}, 64'd5287);

    // back-pressure: four closing beats, consumer stalled until cycle 10
    for (int b = 0; b < 4; b++) bexp[b] = beat_sum(0, vec1, bp_mask[b]) & ow_mask(0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_last = 1'b1; in_addends = vec1; in_mask = bp_mask[0];
    for (int k = 0; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k < 3) in_mask = bp_mask[k+1];
      else       in_valid = 1'b0;
      if (k <= 3) begin
        check_val($sformatf("t4_ready_k%0d", k), {63'b0, rdy[0]}, 64'd1);
        check_val($sformatf("t4_novalid_k%0d", k), {63'b0, ov[0]}, 64'd0);
      end else if (k <= 9) begin
        check_val($sformatf("t4_stall_valid_k%0d", k), {63'b0, ov[0]}, 64'd1);
        check_val($sformatf("t4_stall_ready_k%0d", k), {63'b0, rdy[0]}, 64'd0);
        check_val($sformatf("t4_stall_sum_k%0d", k), {25'b0, sums[0]}, bexp[0]);
      end else if (k <= 12) begin
        check_val($sformatf("t4_drain_valid_k%0d", k), {63'b0, ov[0]}, 64'd1);
        check_val($sformatf("t4_drain_sum_k%0d", k), {25'b0, sums[0]}, bexp[k-9]);
      end else begin
        check_val("t4_drain_done", {63'b0, ov[0]}, 64'd0);
      end
      if (k == 9) out_ready = 1'b1;
    end
    idle(10);

    // reset with a partial group in acc and two beats in flight
    @(posedge clk); #1;
    in_valid = 1'b1; in_last = 1'b0; in_addends = vec1; in_mask = 8'hFF;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("t5_rst_valid", {63'b0, ov[0]}, 64'd0);
    check_val("t5_rst_sum", {25'b0, sums[0]}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    single_beat(vec1, 8'hFF);
    check_val("t5_after_rst_sum", {25'b0, got_sum[0]}, 64'd5287);
    check_val("t5_after_rst_lat", 64'(got_lat[0]), 64'd4);

    // randomized traffic with random consumer stalls
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      in_last   = ($urandom % 3) == 0;
      in_mask   = 8'($urandom);
      for (int i = 0; i < 8; i++) in_addends[i*32 +: 32] = $urandom;
      out_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(20);
    for (int id = 0; id < 4; id++) begin
      check_val($sformatf("rand%0d_pending", id), 64'(wr_p[id] - rd_p[id]), 64'd0);
      check_val($sformatf("rand%0d_outputs_seen", id), {63'b0, (rd_p[id] > 20)}, 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
